// File: rtl/terpine_pkg.sv
// Shared definitions for the result drain slice.
// Holds the drain FSM state encoding and the default channel count / word width.
package terpine_pkg;

  localparam int unsigned N_CHAN_DEF    = 12;
  localparam int unsigned WORD_BITS_DEF = 64;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_CAPTURE = 3'd2,
    S_OUT     = 3'd3,
    S_GAP     = 3'd4
  } state_t;

endpackage

// File: rtl/result_drain_if.sv
// Bundle of the per-channel FIFO handshake and the output word handshake.
//   fifo_empty/fifo_bits/chan_mask : channel side, into the drain
//   fifo_req                       : per-channel shift request, from the drain
//   out_word/out_chan/out_valid    : assembled word, from the drain
//   out_ready                      : consumer accept, into the drain
//   words_drained                  : saturating count of accepted words
// master = drain side, slave = channel/consumer side.
interface result_drain_if
  import terpine_pkg::*;
#(
  parameter int unsigned N_CHAN    = N_CHAN_DEF,
  parameter int unsigned WORD_BITS = WORD_BITS_DEF
) ();
  localparam int unsigned CHAN_W = $clog2(N_CHAN);

  logic [N_CHAN-1:0]    fifo_empty;
  logic [N_CHAN-1:0]    fifo_req;
  logic [N_CHAN-1:0]    fifo_bits;
  logic [N_CHAN-1:0]    chan_mask;
  logic [WORD_BITS-1:0] out_word;
  logic [CHAN_W-1:0]    out_chan;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          words_drained;

  modport master (
    input  fifo_empty, fifo_bits, chan_mask, out_ready,
    output fifo_req, out_word, out_chan, out_valid, words_drained
  );

  modport slave (
    output fifo_empty, fifo_bits, chan_mask, out_ready,
    input  fifo_req, out_word, out_chan, out_valid, words_drained
  );
endinterface

// File: rtl/result_drain_rr_arbiter.sv
// Round-robin arbiter: picks the first set request bit at or above ptr,
// wrapping from N_CHAN-1 to 0.
//   req       : request vector
//   ptr       : starting channel (always < N_CHAN)
//   grant     : one-hot grant
//   grant_idx : index of the granted channel
//   grant_any : at least one request was set
module rr_arbiter
  import terpine_pkg::*;
#(
  parameter  int unsigned N_CHAN = N_CHAN_DEF,
  localparam int unsigned CHAN_W = $clog2(N_CHAN)
) (
  input  logic [N_CHAN-1:0] req,
  input  logic [CHAN_W-1:0] ptr,
  output logic [N_CHAN-1:0] grant,
  output logic [CHAN_W-1:0] grant_idx,
  output logic              grant_any
);

  always_comb begin
    int unsigned      c;
    logic [CHAN_W-1:0] cidx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    c         = 0;
    cidx      = '0;
    for (int unsigned k = 0; k < N_CHAN; k++) begin
      // ptr < N_CHAN, so a single subtraction implements the modulo wrap.
      c = 32'(ptr) + k;
      if (c >= N_CHAN) c = c - N_CHAN;
      cidx = CHAN_W'(c);
      if (!grant_any && req[cidx]) begin
        grant[cidx] = 1'b1;
        grant_idx   = cidx;
        grant_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/result_drain.sv
// Result drain: round-robin selects a non-empty, enabled channel, clocks
// WORD_BITS serial bits out of it (MSB first), presents the assembled word
// with its channel index until accepted, then idles GAP cycles.
//   fifo_clk : clock (rising edge)
//   fifo_rst : synchronous active-high reset
//   bus      : result_drain_if master modport (channel and output handshakes)
module result_drain
  import terpine_pkg::*;
#(
  parameter int unsigned N_CHAN    = N_CHAN_DEF,
  parameter int unsigned WORD_BITS = WORD_BITS_DEF,
  parameter int unsigned GAP       = 2
) (
  input  logic           fifo_clk,
  input  logic           fifo_rst,
  result_drain_if.master bus
);

  localparam int unsigned CHAN_W = $clog2(N_CHAN);
  localparam int unsigned CNT_W  = $clog2(WORD_BITS) + 1;

  state_t               state;
  logic [CHAN_W-1:0]    rr_ptr;
  logic [CHAN_W-1:0]    grant_idx;
  logic [N_CHAN-1:0]    eligible;
  logic [N_CHAN-1:0]    grant;
  logic                 grant_any;
  logic                 cap_due;
  logic [CNT_W-1:0]     cnt;
  logic [WORD_BITS-1:0] sr;

  assign eligible     = ~bus.fifo_empty & bus.chan_mask;
  assign bus.out_word = sr;

  rr_arbiter #(.N_CHAN(N_CHAN)) u_arb (
    .req       (eligible),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_ff @(posedge fifo_clk) begin
    if (fifo_rst) begin
      state             <= S_IDLE;
      bus.fifo_req      <= '0;
      bus.out_valid     <= 1'b0;
      bus.out_chan      <= '0;
      bus.words_drained <= '0;
      rr_ptr            <= '0;
      cnt               <= '0;
      cap_due           <= 1'b0;
      sr                <= '0;
    end else begin
      // A bit arrives the cycle after each request; the shift register
      // doubles as out_word and is frozen whenever no bit is due.
      cap_due <= |bus.fifo_req;
      if (cap_due) sr <= {sr[WORD_BITS-2:0], |bus.fifo_bits};

      case (state)
        S_IDLE: begin
          if (grant_any) begin
            bus.out_chan <= grant_idx;
            bus.fifo_req <= grant;
            cnt          <= '0;
            state        <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (cnt == CNT_W'(WORD_BITS - 1)) begin
            bus.fifo_req <= '0;
            state        <= S_CAPTURE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          bus.out_valid <= 1'b1;
          state         <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (bus.words_drained != '1)
              bus.words_drained <= bus.words_drained + 32'd1;
            rr_ptr <= (bus.out_chan == CHAN_W'(N_CHAN - 1)) ? '0 : bus.out_chan + 1'b1;
            cnt    <= '0;
            state  <= S_GAP;
          end
        end
        S_GAP: begin
          if (cnt == CNT_W'(GAP - 1)) state <= S_IDLE;
          else                        cnt   <= cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
